gray_conv_arbiter: RTL and testbench
====================================

Name: gray_conv_arbiter

Overview:
- Shares one WIDTH-bit binary-to-Gray conversion datapath between N_REQ requesters.
- Round-robin arbitration selects one requester per cycle and acknowledges it.
- The Gray result is registered, tagged with the requester id, and offered downstream on a valid/ready handshake with backpressure.
- Sits between the requesting blocks and the shared converter; also keeps a running count of completed conversions.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, binary/Gray word width.
- CNT_W, 8, width of the completed-conversion counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- bin_in  input  N_REQ*WIDTH  requester i's binary word in bits [i*WIDTH +: WIDTH].
- ack  output  N_REQ  one-hot, one-cycle pulse: this requester's word was captured this cycle.
- out_valid  output  1  out_gray, out_bin and out_id hold a result.
- out_ready  input  1  downstream accepts the result.
- out_gray  output  WIDTH  Gray code of the granted word.
- out_bin  output  WIDTH  original binary word, echoed back.
- out_id  output  clog2(N_REQ)  index of the requester the result belongs to.
- conv_count  output  CNT_W  number of results accepted downstream (out_valid && out_ready).

Behaviour:
- Reset: ack=0, out_valid=0, out_gray=0, out_bin=0, out_id=0, conv_count=0, rr_ptr=0 (requester 0 highest priority). Reset overrides everything; an in-flight result is discarded without being counted.
- Conversion function: g[WIDTH-1]=b[WIDTH-1]; g[i]=b[i+1]^b[i] for i<WIDTH-1. Purely combinational inside the datapath.
- can_load = !out_valid || out_ready. The output slot is empty, or is being drained this cycle.
- Arbitration is combinational, each cycle, when can_load=1 and |req=1:
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - ack[winner]=1 in that same cycle.
  - At the clock edge: out_gray/out_bin/out_id <= the winner's converted word; out_valid <= 1; rr_ptr <= (winner+1) mod N_REQ.
- When can_load=0 (out_valid=1 and out_ready=0):
  - ack=0 and the output registers hold stable.
  - rr_ptr does not move.
  - Requests stay pending; nothing is dropped.
- When out_valid=1 and out_ready=1 with no req pending: out_valid <= 0 at the edge.
- Latency: req rising in cycle n with the slot free gives ack in cycle n and out_valid in cycle n+1.
- Throughput: with out_ready held high, one result per cycle.
- Requester contract: on ack it either drops req or presents its next word the following cycle. A req held high is treated as a new request.
- Fairness: under continuous requests from all N_REQ requesters, each is granted exactly once in every N_REQ consecutive grants.
- Simultaneous drain and load in one cycle: counts as an accept (conv_count increments) and a new capture (out_valid stays 1).
- conv_count increments on every out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- bin_in of requesters that are not granted is ignored; X on those inputs must not propagate.
- Only ack and the arbitration logic are combinational from req; every other output is registered.

Decomposition:
- Package gray_conv_pkg holds:
  - the default WIDTH/N_REQ constants;
  - an ID_W function giving clog2(N_REQ), minimum 1;
  - the Gray conversion function, so the existing converter and this block share one definition.
- One sub-module, rr_arbiter (N_REQ-wide, round-robin, with rr_ptr internal and grant-enable input).
- The datapath stays inline in the top level.

Test Plan:
- Reset then single request: rst high 2 cycles, drop; req=0001, bin_in[3:0]=0101, out_ready=1 -> ack=0001 same cycle; next cycle out_valid=1, out_gray=0111, out_bin=0101, out_id=0; conv_count=1 after.
- Full sweep: requester 2 steps bin 0000..1111 one per ack -> out_gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; conv_count=16.
- Round-robin: all req=1111 held, out_ready=1 -> out_id 0,1,2,3,0,1,... with each ack bit one-hot in turn.
- Backpressure: out_ready=0 with out_valid=1, req=1111 for 5 cycles -> outputs stable, ack=0000, conv_count unchanged; release -> grants resume at the next requester after the held one.
- Counter wrap with CNT_W=2: 5 accepted results -> conv_count 1,2,3,0,1.
- Mid-operation reset: rst during out_valid=1, out_ready=0 -> next cycle out_valid=0, conv_count=0; first subsequent grant goes to requester 0 when req=1111.

Source files
------------

// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray conversion block and its requester arbiter.
//   DEFAULT_N_REQ / DEFAULT_WIDTH : default requester count and word width
//   id_w(n)                       : width of a requester index, never below 1
//   bin2gray(b)                   : binary-to-Gray conversion used by every converter
package gray_conv_pkg;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_WIDTH = 4;

  // Widest word the shared conversion function handles; callers narrow the result.
  localparam int GRAY_MAX_W = 32;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // g[msb] = b[msb], g[i] = b[i+1] ^ b[i]; zero-extended upper bits keep the
  // narrowed result exact for any width up to GRAY_MAX_W.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   clk, rst    : clock, synchronous active-high reset (pointer back to 0)
//   en          : arbitration allowed this cycle (downstream slot can load)
//   req         : level-sensitive requests
//   grant       : one-hot grant, combinational from req
//   grant_valid : a grant is being issued this cycle
//   grant_id    : index of the granted requester
module rr_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [id_w(N_REQ)-1:0]   grant_id
);

  localparam int ID_W = id_w(N_REQ);

  logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [N_REQ-1:0] high_mask;
  logic [N_REQ-1:0] high_req;
  logic [ID_W-1:0]  high_id, low_id, win_id;
  logic             high_any;

  // Requests at or above the pointer are searched first; if none, the search
  // wraps to the lowest requester overall.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
      assign high_mask[gi] = (ID_W'(gi) >= rr_ptr_reg);
      assign grant[gi]     = grant_valid && (win_id == ID_W'(gi));
    end
  endgenerate

  assign high_req = req & high_mask;
  assign high_any = |high_req;

  always_comb begin
    high_id = '0;
    low_id  = '0;
    // Downward scan leaves the lowest set index in each result.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (high_req[i]) high_id = ID_W'(i);
      if (req[i])      low_id  = ID_W'(i);
    end
  end

  assign win_id      = high_any ? high_id : low_id;
  assign grant_valid = en && (|req);
  assign grant_id    = win_id;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_reg <= '0;
    else     rr_ptr_reg <= rr_ptr_next;
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one binary-to-Gray converter between N_REQ requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester level request
//   bin_in     : requester i's word in bits [i*WIDTH +: WIDTH]
//   ack        : one-hot pulse, the requester's word is captured this cycle
//   out_valid  : out_gray / out_bin / out_id hold a result
//   out_ready  : downstream accepts the result
//   out_gray   : Gray code of the captured word
//   out_bin    : captured binary word
//   out_id     : requester index the result belongs to
//   conv_count : wrapping count of results accepted downstream
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   bin_in,
  output logic [N_REQ-1:0]         ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_gray,
  output logic [WIDTH-1:0]         out_bin,
  output logic [id_w(N_REQ)-1:0]   out_id,
  output logic [CNT_W-1:0]         conv_count
);

  localparam int ID_W = id_w(N_REQ);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_gray_reg, out_bin_reg;
  logic [ID_W-1:0]  out_id_reg;
  logic [CNT_W-1:0] conv_count_reg;

  logic             can_load;
  logic             arb_en;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH-1:0] sel_bin;
  logic [WIDTH-1:0] sel_gray;
  logic             accept;

  // The slot may take a new word when empty or when it is draining this cycle.
  assign can_load = !out_valid_reg || out_ready;
  assign arb_en   = can_load && !rst;
  assign accept   = out_valid_reg && out_ready;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // AND-OR select on the one-hot grant: words of ungranted requesters never
  // reach the datapath, so X on them cannot leak into the result.
  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_bin = sel_bin | bin_in[i*WIDTH +: WIDTH];
    end
  end

  assign sel_gray = WIDTH'(bin2gray(GRAY_MAX_W'(sel_bin)));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_gray_reg   <= '0;
      out_bin_reg    <= '0;
      out_id_reg     <= '0;
      conv_count_reg <= '0;
    end else begin
      if (accept) conv_count_reg <= conv_count_reg + 1'b1;
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_gray_reg  <= sel_gray;
        out_bin_reg   <= sel_bin;
        out_id_reg    <= grant_id;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign ack        = grant;
  assign out_valid  = out_valid_reg;
  assign out_gray   = out_gray_reg;
  assign out_bin    = out_bin_reg;
  assign out_id     = out_id_reg;
  assign conv_count = conv_count_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized scoreboard bench for gray_conv_arbiter.
module tb_gray_conv_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] bin_in;
  logic [N_REQ-1:0]       ack;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_gray;
  logic [WIDTH-1:0]       out_bin;
  logic [ID_W-1:0]        out_id;
  logic [CNT_W-1:0]       conv_count;

  gray_conv_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin_in    (bin_in),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .conv_count(conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic [ID_W-1:0]  id;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   acc    = 0;

  // Reference model state: rotating priority start and slot occupancy.
  int   m_ptr  = 0;
  bit   m_full = 0;
  bit   have_pending = 0;
  res_t pending;

  function automatic logic [WIDTH-1:0] gray_ref(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  // One clock cycle: apply inputs shortly after the edge, predict the grant,
  // check ack combinationally, and queue the expected result for the monitor.
  task automatic step(input logic r, input logic [N_REQ-1:0] rq,
                      input logic [N_REQ*WIDTH-1:0] b, input logic rdy);
    int               win;
    logic [N_REQ-1:0] exp_ack;
    logic [WIDTH-1:0] w;
    @(posedge clk);
    #1;
    if (have_pending) begin
      exp_q.push_back(pending);
      have_pending = 0;
    end
    rst = r; req = rq; bin_in = b; out_ready = rdy;
    win = -1;
    exp_ack = '0;
    if (!r && (!m_full || rdy)) begin
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_ptr + k) % N_REQ;
        if (win < 0 && rq[i]) win = i;
      end
    end
    if (win >= 0) begin
      exp_ack[win] = 1'b1;
      w = b[win*WIDTH +: WIDTH];
      pending.bin  = w;
      pending.gray = gray_ref(w);
      pending.id   = win[ID_W-1:0];
      have_pending = 1;
    end
    #1;
    checks++;
    if (ack !== exp_ack) begin
      errors++;
      $display("FAIL ack t=%0t got=%b exp=%b", $time, ack, exp_ack);
    end
    if (r) begin
      m_ptr = 0; m_full = 0;
    end else if (win >= 0) begin
      m_ptr = (win + 1) % N_REQ; m_full = 1;
    end else if (rdy) begin
      m_full = 0;
    end
  endtask

  // Monitor: compares the presented result against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          exp_q.delete();
          acc = 0;
        end else begin
          checks++;
          if (out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_q.size() != 0);
          end
          checks++;
          if (conv_count !== CNT_W'(acc)) begin
            errors++;
            $display("FAIL conv_count t=%0t got=%0d exp=%0d", $time, conv_count, CNT_W'(acc));
          end
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            acc++;
            if (exp_q.size() > 0) begin
              res_t e;
              e = exp_q.pop_front();
              checks++;
              if (out_gray !== e.gray || out_bin !== e.bin || out_id !== e.id) begin
                errors++;
                $display("FAIL result t=%0t got gray=%b bin=%b id=%0d exp gray=%b bin=%b id=%0d",
                         $time, out_gray, out_bin, out_id, e.gray, e.bin, e.id);
              end
              $display("accept id=%0d bin=%b gray=%b count=%0d", out_id, out_bin, out_gray, conv_count);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [N_REQ*WIDTH-1:0] b;
    rst = 1'b1; req = '0; bin_in = '0; out_ready = 1'b1;

    // Reset, then the monitor starts checking the idle reset state.
    step(1'b1, '0, '0, 1'b1);
    step(1'b1, '0, '0, 1'b1);
    mon_en = 1;

    // Single request; other requesters' words are X and must not matter.
    b = 'x;
    b[3:0] = 4'b0101;
    step(1'b0, 4'b0001, b, 1'b1);
    step(1'b0, 4'b0000, '0, 1'b1);
    #3;
    checks++;
    if (out_valid !== 1'b1 || out_gray !== 4'b0111 || out_bin !== 4'b0101 || out_id !== 2'd0) begin
      errors++;
      $display("FAIL single got v=%b gray=%b bin=%b id=%0d exp v=1 gray=0111 bin=0101 id=0",
               out_valid, out_gray, out_bin, out_id);
    end
    step(1'b0, 4'b0000, '0, 1'b1);

    // Requester 2 sweeps every binary word.
    for (int v = 0; v < 16; v++) begin
      b = {$urandom, $urandom};
      b[11:8] = v[3:0];
      step(1'b0, 4'b0100, b, 1'b1);
    end
    step(1'b0, 4'b0000, '0, 1'b1);

    // All requesting continuously: grants rotate.
    for (int n = 0; n < 12; n++) step(1'b0, 4'b1111, N_REQ*WIDTH'($urandom), 1'b1);

    // Backpressure with everybody requesting, then release.
    for (int n = 0; n < 5; n++) step(1'b0, 4'b1111, N_REQ*WIDTH'($urandom), 1'b0);
    for (int n = 0; n < 4; n++) step(1'b0, 4'b1111, N_REQ*WIDTH'($urandom), 1'b1);

    // Random traffic; long enough for the counter to wrap.
    for (int n = 0; n < 700; n++) begin
      step(1'b0, N_REQ'($urandom), N_REQ*WIDTH'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Reset while a result is stalled, then everyone requests.
    step(1'b0, 4'b1111, N_REQ*WIDTH'($urandom), 1'b0);
    step(1'b0, 4'b1111, N_REQ*WIDTH'($urandom), 1'b0);
    step(1'b1, 4'b1111, N_REQ*WIDTH'($urandom), 1'b0);
    for (int n = 0; n < 4; n++) step(1'b0, 4'b1111, N_REQ*WIDTH'($urandom), 1'b1);

    // Drain.
    for (int n = 0; n < 3; n++) step(1'b0, 4'b0000, '0, 1'b1);
    @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0 || have_pending) begin
      errors++;
      $display("FAIL drain got pending=%0d exp=0", exp_q.size() + int'(have_pending));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
